// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and defaults for the HI/LO sequencer
package muldiv_pkg;

  localparam int DEFAULT_MAX_CYCLES = 64;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN_MUL = 2'b01,
    ST_RUN_DIV = 2'b10,
    ST_RELEASE = 2'b11
  } state_t;

  function automatic logic is_move_to(input logic [1:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/hilo_watchdog.sv
// rtl/hilo_watchdog.sv - per-operation cycle counter; expired flags the last allowed run cycle
module hilo_watchdog
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);
  assign expired   = enable && w_at_last;

  // Saturates at LAST so a stalled FSM can never wrap back to an early count.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && !w_at_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - MULT/DIV sequencer and architectural HI/LO register file
// Holds the selected unit's run enable until its final flag, then forces one release cycle.
module hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] mt_data,
  input  logic        div_final,
  input  logic        div_zero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        mult_final,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        div_control,
  output logic        mult_control,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic        timeout_exc
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] w_hi_next;
  logic [31:0] w_lo_next;
  logic        r_div_control;
  logic        r_mult_control;
  logic        r_busy;
  logic        r_done;
  logic        r_div_zero_exc;
  logic        r_timeout_exc;
  logic        w_done_next;
  logic        w_set_div_zero;
  logic        w_set_timeout;
  logic        w_clear_flags;
  logic        w_running;
  logic        w_expired;

  assign w_running = (r_state == ST_RUN_MUL) || (r_state == ST_RUN_DIV);

  hilo_watchdog #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (!w_running),
    .enable  (w_running),
    .expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_hi_next      = r_hi;
    w_lo_next      = r_lo;
    w_done_next    = 1'b0;
    w_set_div_zero = 1'b0;
    w_set_timeout  = 1'b0;
    w_clear_flags  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clear_flags = 1'b1;
          unique case (op)
            OP_MULT: w_next_state = ST_RUN_MUL;
            OP_DIV:  w_next_state = ST_RUN_DIV;
            OP_MTHI: w_hi_next    = mt_data;
            OP_MTLO: w_lo_next    = mt_data;
          endcase
          w_done_next = is_move_to(op);
        end
      end
      // A final flag on the expiry edge wins over the watchdog.
      ST_RUN_DIV: begin
        if (div_final) begin
          w_next_state = ST_RELEASE;
          w_done_next  = 1'b1;
          if (div_zero) begin
            w_set_div_zero = 1'b1;
          end else begin
            w_hi_next = div_hi;
            w_lo_next = div_lo;
          end
        end else if (w_expired) begin
          w_next_state  = ST_RELEASE;
          w_done_next   = 1'b1;
          w_set_timeout = 1'b1;
        end
      end
      ST_RUN_MUL: begin
        if (mult_final) begin
          w_next_state = ST_RELEASE;
          w_done_next  = 1'b1;
          w_hi_next    = mult_hi;
          w_lo_next    = mult_lo;
        end else if (w_expired) begin
          w_next_state  = ST_RELEASE;
          w_done_next   = 1'b1;
          w_set_timeout = 1'b1;
        end
      end
      ST_RELEASE: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Control lines and busy are decoded from the next state so they leave a flop directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi           <= '0;
      r_lo           <= '0;
      r_div_control  <= 1'b0;
      r_mult_control <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_div_zero_exc <= 1'b0;
      r_timeout_exc  <= 1'b0;
    end else begin
      r_hi           <= w_hi_next;
      r_lo           <= w_lo_next;
      r_div_control  <= (w_next_state == ST_RUN_DIV);
      r_mult_control <= (w_next_state == ST_RUN_MUL);
      r_busy         <= (w_next_state != ST_IDLE);
      r_done         <= w_done_next;
      r_div_zero_exc <= w_set_div_zero | (r_div_zero_exc & ~w_clear_flags);
      r_timeout_exc  <= w_set_timeout  | (r_timeout_exc  & ~w_clear_flags);
    end
  end

  assign div_control  = r_div_control;
  assign mult_control = r_mult_control;
  assign hi_out       = r_hi;
  assign lo_out       = r_lo;
  assign busy         = r_busy;
  assign done         = r_done;
  assign div_zero_exc = r_div_zero_exc;
  assign timeout_exc  = r_timeout_exc;

endmodule
